// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw pins in, debounced level and press/release events out.
// master = user/board side driving the pins, slave = btn_debounce.
interface btn_debounce_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_state;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output btn_in,
        input  btn_state,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_state,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: per-channel 2-flop synchronizer followed by a confirm-counter FSM.
// A new level is accepted only after 2**DB_LOG2 consecutive mismatching samples;
// acceptance emits a single-cycle press (0->1) or release (1->0) pulse.
// Optional feature: define BTN_DEBOUNCE_AUTOREPEAT_EN to re-fire btn_press every
// 2**RPT_LOG2 cycles while a button is held.
module btn_debounce #(
    parameter int NUM_BTN  = 4,
    parameter int DB_LOG2  = 16,
    parameter int RPT_LOG2 = 22
) (
    input  logic          clk,
    input  logic          resetn,
    btn_debounce_if.slave bus
);

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } db_state_t;

    // Reject configurations where a counter would have no bits.
    if (DB_LOG2 < 1 || RPT_LOG2 < 1) begin : g_bad_param
        $error("btn_debounce: DB_LOG2 and RPT_LOG2 must be at least 1");
    end

    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;
    logic [NUM_BTN-1:0] state_v;
    logic [NUM_BTN-1:0] press_v;
    logic [NUM_BTN-1:0] release_v;

    // Stage 0 -> 1: two-flop synchronizer for the asynchronous pins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.btn_in;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        db_state_t          st;
        logic [DB_LOG2-1:0] cnt;
        logic               lvl;
        logic               prs;
        logic               rls;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        logic [RPT_LOG2-1:0] rpt;
`endif

        // Stage 1 -> 2: confirm-counter FSM with registered level and event outputs
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                st  <= STABLE;
                cnt <= '0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rls <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                rpt <= '0;
`endif
            end else begin
                prs <= 1'b0;
                rls <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                // Repeat timer runs only while the accepted level is high; an
                // acceptance below overrides it (release cancels, press restarts).
                if (!lvl) begin
                    rpt <= '0;
                end else if (rpt == '1) begin
                    rpt <= '0;
                    prs <= 1'b1;
                end else begin
                    rpt <= rpt + 1'b1;
                end
`endif
                case (st)
                    STABLE: begin
                        if (s2[g] != lvl) begin
                            st  <= CONFIRM;
                            cnt <= DB_LOG2'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    CONFIRM: begin
                        if (s2[g] == lvl) begin
                            // Bounce back to the old level: drop the pending change.
                            st  <= STABLE;
                            cnt <= '0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            lvl <= s2[g];
                            cnt <= '0;
                            st  <= STABLE;
                            prs <= s2[g];
                            rls <= ~s2[g];
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                            rpt <= '0;
`endif
                        end
                    end
                    default: begin
                        st  <= STABLE;
                        cnt <= '0;
                    end
                endcase
            end
        end

        assign state_v[g]   = lvl;
        assign press_v[g]   = prs;
        assign release_v[g] = rls;
    end

    assign bus.btn_state   = state_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed testbench for btn_debounce with DB_LOG2=2 (5-edge latency), RPT_LOG2=3.
module tb_btn_debounce;

    localparam int NUM_BTN  = 4;
    localparam int DB_LOG2  = 2;
    localparam int RPT_LOG2 = 3;
    localparam int LAT      = 5;   // 2 sync edges + 2**DB_LOG2 - 1 count edges
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    btn_debounce_if #(.NUM_BTN(NUM_BTN)) bif ();

    btn_debounce #(
        .NUM_BTN (NUM_BTN),
        .DB_LOG2 (DB_LOG2),
        .RPT_LOG2(RPT_LOG2)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_s, exp_p;
        resetn     = 1'b0;
        bif.btn_in = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bif.btn_state, bif.btn_press, bif.btn_release} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold k=%0d state=%h press=%h release=%h required all 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release);
            end
        end
        resetn = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            exp_s = (k >= LAT) ? 4'hF : 4'h0;
            exp_p = (k == LAT) ? 4'hF : 4'h0;
            checks++;
            if (bif.btn_state !== exp_s || bif.btn_press !== exp_p || bif.btn_release !== 4'h0) begin
                errors++;
                $display("FAIL reset_release_latency edge=%0d state=%h press=%h release=%h required %h %h 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release, exp_s, exp_p);
            end
        end
        bif.btn_in = 4'h0;
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            exp_s = (k >= LAT) ? 4'h0 : 4'hF;
            exp_p = (k == LAT) ? 4'hF : 4'h0;
            checks++;
            if (bif.btn_state !== exp_s || bif.btn_release !== exp_p || bif.btn_press !== 4'h0) begin
                errors++;
                $display("FAIL reset_all_release edge=%0d state=%h press=%h release=%h required %h 0 %h",
                         k, bif.btn_state, bif.btn_press, bif.btn_release, exp_s, exp_p);
            end
        end
    endtask

    task automatic test_press_release();
        logic es, ep;
        bif.btn_in[0] = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            es = (k >= LAT);
            ep = (k == LAT);
            checks++;
            if (bif.btn_state !== {3'b0, es} || bif.btn_press !== {3'b0, ep} || bif.btn_release !== 4'h0) begin
                errors++;
                $display("FAIL clean_press edge=%0d state=%h press=%h release=%h required %h %h 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release, {3'b0, es}, {3'b0, ep});
            end
        end
        bif.btn_in[0] = 1'b0;
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            es = (k < LAT);
            ep = (k == LAT);
            checks++;
            if (bif.btn_state !== {3'b0, es} || bif.btn_release !== {3'b0, ep} || bif.btn_press !== 4'h0) begin
                errors++;
                $display("FAIL clean_release edge=%0d state=%h press=%h release=%h required %h 0 %h",
                         k, bif.btn_state, bif.btn_press, bif.btn_release, {3'b0, es}, {3'b0, ep});
            end
        end
    endtask

    task automatic test_glitch();
        logic [6:0] bounce;
        logic       es, ep;
        // Three-cycle high pulse is one sample short of acceptance.
        for (int k = 0; k < 12; k++) begin
            bif.btn_in[1] = (k < 3);
            tick();
            checks++;
            if (bif.btn_state !== 4'h0 || bif.btn_press !== 4'h0 || bif.btn_release !== 4'h0) begin
                errors++;
                $display("FAIL glitch_short edge=%0d state=%h press=%h release=%h required all 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release);
            end
        end
        // Bounce 1,1,0 then steady high: accepted 5 edges after the first steady high (edge 3).
        bounce = 7'b1111011;   // bit k is the level before edge k
        for (int k = 0; k <= 10; k++) begin
            bif.btn_in[1] = (k < 7) ? bounce[k] : 1'b1;
            tick();
            es = (k >= 8);
            ep = (k == 8);
            checks++;
            if (bif.btn_state !== {2'b0, es, 1'b0} || bif.btn_press !== {2'b0, ep, 1'b0} ||
                bif.btn_release !== 4'h0) begin
                errors++;
                $display("FAIL glitch_bounce edge=%0d state=%h press=%h release=%h required %h %h 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release, {2'b0, es, 1'b0}, {2'b0, ep, 1'b0});
            end
        end
        bif.btn_in[1] = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            ep = (k == LAT);
            checks++;
            if (bif.btn_release !== {2'b0, ep, 1'b0} || bif.btn_press !== 4'h0) begin
                errors++;
                $display("FAIL glitch_release edge=%0d press=%h release=%h required 0 %h",
                         k, bif.btn_press, bif.btn_release, {2'b0, ep, 1'b0});
            end
        end
    endtask

    task automatic test_independence();
        logic [3:0] exp_s, exp_p;
        bif.btn_in[3] = 1'b1;
        for (int k = 0; k <= LAT + 2; k++) begin
            tick();
            if (k == 0) bif.btn_in[2] = 1'b1;
            exp_s = {(k >= LAT), (k >= LAT + 1), 2'b00};
            exp_p = {(k == LAT), (k == LAT + 1), 2'b00};
            checks++;
            if (bif.btn_state !== exp_s || bif.btn_press !== exp_p || bif.btn_release !== 4'h0) begin
                errors++;
                $display("FAIL independence edge=%0d state=%h press=%h release=%h required %h %h 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release, exp_s, exp_p);
            end
        end
        bif.btn_in[3:2] = 2'b00;
        for (int k = 0; k <= LAT; k++) begin
            tick();
            exp_p = (k == LAT) ? 4'hC : 4'h0;
            checks++;
            if (bif.btn_release !== exp_p || bif.btn_press !== 4'h0) begin
                errors++;
                $display("FAIL independence_release edge=%0d press=%h release=%h required 0 %h",
                         k, bif.btn_press, bif.btn_release, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid_confirm();
        int npress;
        bif.btn_in[0] = 1'b1;
        // Edge 2 enters CONFIRM, edge 3 is the second cycle in it.
        for (int k = 0; k < 4; k++) tick();
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bif.btn_state, bif.btn_press, bif.btn_release} !== 12'h000) begin
                errors++;
                $display("FAIL midreset_hold k=%0d state=%h press=%h release=%h required all 0",
                         k, bif.btn_state, bif.btn_press, bif.btn_release);
            end
        end
        resetn = 1'b1;
        npress = 0;
        for (int k = 0; k <= LAT + 2; k++) begin
            tick();
            if (bif.btn_press[0]) npress++;
            checks++;
            if (bif.btn_press[0] !== (k == LAT) || bif.btn_state[0] !== (k >= LAT)) begin
                errors++;
                $display("FAIL midreset_repress edge=%0d state0=%b press0=%b required %b %b",
                         k, bif.btn_state[0], bif.btn_press[0], (k >= LAT), (k == LAT));
            end
        end
        checks++;
        if (npress !== 1) begin
            errors++;
            $display("FAIL midreset_press_count got=%0d required=1", npress);
        end
        bif.btn_in[0] = 1'b0;
        for (int k = 0; k <= LAT; k++) tick();
        checks++;
        if (bif.btn_state !== 4'h0) begin
            errors++;
            $display("FAIL midreset_cleanup state=%h required 0", bif.btn_state);
        end
    endtask

    task automatic test_autorepeat();
        logic ep;
        int   d;
        bif.btn_in[0] = 1'b1;
        // Press lands at edge LAT; hold 30 more edges.
        for (int k = 0; k <= LAT + 30; k++) begin
            tick();
            d  = k - LAT;
            ep = (d == 0) || (RPT_ON && d > 0 && (d % 8) == 0);
            checks++;
            if (bif.btn_press !== {3'b0, ep} || bif.btn_release !== 4'h0) begin
                errors++;
                $display("FAIL autorepeat edge=%0d press=%h release=%h required %h 0",
                         k, bif.btn_press, bif.btn_release, {3'b0, ep});
            end
        end
        bif.btn_in[0] = 1'b0;
        for (int k = 0; k <= LAT + 10; k++) begin
            tick();
            ep = (k == LAT);
            checks++;
            if (bif.btn_release !== {3'b0, ep} || bif.btn_press !== 4'h0) begin
                errors++;
                $display("FAIL autorepeat_release edge=%0d press=%h release=%h required 0 %h",
                         k, bif.btn_press, bif.btn_release, {3'b0, ep});
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        bif.btn_in = '0;
        test_reset();
        test_press_release();
        test_glitch();
        test_independence();
        test_reset_mid_confirm();
        test_autorepeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart to the counter-driven LED outputs: conditions NUM_BTN raw push-button/switch pins into clean, glitch-free levels and single-cycle press/release events.
- Sits between the board's button IOBs and user logic (e.g. to step or reset an LED counter).
- Per channel: 2-flop synchronizer, then a confirm-counter FSM.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DB_LOG2, 16, debounce window: the synchronized input must hold its new level for 2**DB_LOG2 consecutive cycles before it is accepted.
- RPT_LOG2, 22, auto-repeat period exponent; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock (already buffered through the global clock network).
- resetn  input  1  asynchronous active-low reset.
- btn_in  input  NUM_BTN  raw button pins; asynchronous to clk, active-high.
- btn_state  output  NUM_BTN  debounced level per channel.
- btn_press  output  NUM_BTN  1-cycle pulse per channel on an accepted 0->1 transition (and on repeats, if enabled).
- btn_release  output  NUM_BTN  1-cycle pulse per channel on an accepted 1->0 transition.

Behaviour:
- Interface (already decided): one clock, clk; reset resetn is asynchronous, active-low.
- Reset (async assert, sync-safe deassert by design use):
  - Synchronizer flops, state, counters and all outputs clear to 0 immediately.
  - FSM goes to STABLE.
- Synchronizer: s1 <= btn_in, then s2 <= s1. Only s2 is used downstream. All channels are fully independent.
- FSM per channel:
  - STABLE: cnt = 0. If s2 != btn_state, go to CONFIRM and set cnt <= 1; otherwise hold.
  - CONFIRM, s2 == btn_state (glitch ended): return to STABLE, cnt <= 0, no pulse.
  - CONFIRM, s2 != btn_state and cnt != all-ones: cnt <= cnt + 1.
  - CONFIRM, s2 != btn_state and cnt == all-ones (2**DB_LOG2 mismatching cycles seen):
    - btn_state <= s2; cnt <= 0; go to STABLE.
    - Assert btn_press (new level 1) or btn_release (new level 0) in the same cycle btn_state changes.
- cnt is DB_LOG2 bits wide. Wrap is never used; acceptance occurs exactly at all-ones.
- Latency: a pin change settled before clock edge 0 makes btn_state change after edge 1+2**DB_LOG2 (2 sync edges + 2**DB_LOG2 - 1 count edges). All outputs are registered.
- Boundary conditions:
  - Mismatch lasting 2**DB_LOG2 - 1 cycles or fewer: ignored.
  - Input bouncing back during CONFIRM restarts the full window.
  - Events are only ever single-cycle; press and release can never assert together on one channel.
  - Reset asserted mid-CONFIRM aborts the pending acceptance. After deassert, a pin held high needs the full latency again, then produces one press pulse.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
- With the macro defined:
  - Per-channel RPT_LOG2-bit rpt counter, cleared on reset, on the press pulse, and whenever btn_state = 0.
  - While btn_state = 1: rpt increments each cycle. At all-ones it wraps to 0 and btn_press pulses for 1 cycle.
  - Repeats therefore fire at press-cycle + k*2**RPT_LOG2, k = 1, 2, ...
  - A release pulse cancels repeats in the same cycle.
- Without the macro: no rpt logic; exactly one btn_press per accepted press.

Test Plan (DB_LOG2=2, RPT_LOG2=3, NUM_BTN=4):
- Reset: hold resetn=0 with btn_in=4'hF -> btn_state=0, btn_press=0, btn_release=0. Raise resetn with btn_in still 4'hF -> btn_state=4'hF exactly 5 edges later, with btn_press=4'hF for exactly that one cycle.
- Clean press/release: btn_in[0] 0->1 before edge 0 -> btn_state[0]=1 after edge 5, btn_press[0] high only in that cycle. Drop to 0 -> btn_release[0] single pulse 5 edges later.
- Glitch: btn_in[1] high for 3 cycles, then low -> btn_state[1] stays 0, no pulses. Bounce 1,1,0,1,1,1,1 -> accepted only after the final 4 consecutive highs.
- Independence: btn_in[2] rises 1 cycle after btn_in[3] -> press pulses 1 cycle apart; no cross-channel effect.
- Reset mid-operation: drop resetn 2 cycles into CONFIRM on ch0 -> no pulse during reset. After deassert, a held-high pin gives exactly one press pulse after 5 edges.
- With BTN_DEBOUNCE_AUTOREPEAT_EN: hold ch0 high 30 cycles past press -> btn_press[0] pulses at press+8, +16, +24. Without the macro -> only the initial pulse.
